carbon_uart_tx: RTL and testbench

//   Serial transmitter for the MMIO console byte stream (uart_tx_valid/uart_tx_byte pulses).

---
 rtl/carbon_uart_pkg.sv | 9 +
 rtl/carbon_sync_fifo.sv | 59 +++++
 rtl/carbon_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_carbon_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carbon_uart_pkg.sv
// Shared types and constants for the carbon UART transmitter.
package carbon_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

    localparam int unsigned CARBON_UART_DATA_BITS        = 8;
    localparam int unsigned CARBON_UART_DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/carbon_sync_fifo.sv
// Synchronous FIFO with registered level; a push is never visible on rdata in the same cycle.
module carbon_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_ok, pop_ok;

    // Full/empty come from the registered level only, so a pop cannot make room for a
    // push in the same cycle.
    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/carbon_uart_tx.sv
// Buffered 8N1 serial transmitter, LSB first. Define CARBON_UART_TX_PARITY_EN for an
// even-parity bit between the data and stop bits.
module carbon_uart_tx
    import carbon_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = CARBON_UART_DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        tx_valid_i,
    input  logic [7:0]                  tx_byte_i,
    input  logic                        overflow_clr_i,
    output logic                        txd_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o
);

    localparam int unsigned BaudW = $clog2(BAUD_DIV);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [2:0] BitLast = 3'(CARBON_UART_DATA_BITS - 1);

    uart_tx_state_e   state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             txd_q;
    logic             overflow_q;

    logic       pop;
    logic       baud_end;
    logic [7:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;

    carbon_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_valid_i),
        .wdata_i (tx_byte_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign baud_end = (baud_q == '0);
    // The end of a stop bit pops straight into the next start bit with no idle gap.
    assign pop = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_end));

`ifdef CARBON_UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^fifo_rdata;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        state_q <= START;
                        baud_q  <= BaudLast;
                        shift_q <= fifo_rdata;
                        txd_q   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state_q <= DATA;
                        baud_q  <= BaudLast;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q <= BaudLast;
                        if (bit_q == BitLast) begin
`ifdef CARBON_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= parity_q;
`else
                            state_q <= STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
`ifdef CARBON_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state_q <= STOP;
                        baud_q  <= BaudLast;
                        txd_q   <= 1'b1;
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        if (pop) begin
                            state_q <= START;
                            baud_q  <= BaudLast;
                            shift_q <= fifo_rdata;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (tx_valid_i && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign txd_o      = txd_q;
    assign overflow_o = overflow_q;
    assign busy_o     = (state_q != IDLE) || (fifo_level_o != '0);

endmodule

// File: tb/tb_carbon_uart_tx.sv
// Directed and randomized checks of carbon_uart_tx against a frame-level line model.
module tb_carbon_uart_tx;

    localparam int BD = 4;
    localparam int FD = 4;
`ifdef CARBON_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FB  = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int FB  = 10;
`endif

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       overflow_clr;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] mon_byte_q  [$];
    int         mon_start_q [$];
    bit         mon_ok_q    [$];
    bit         mon_par_q   [$];

    carbon_uart_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tx_valid_i     (tx_valid),
        .tx_byte_i      (tx_byte),
        .overflow_clr_i (overflow_clr),
        .txd_o          (txd),
        .busy_o         (busy),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line monitor: decodes frames by sampling mid-bit, records start cycle and framing.
    initial begin
        int t;
        int bi;
        bit inf;
        bit ok;
        bit par;
        int st;
        logic [7:0] b;
        inf = 1'b0;
        t = 0;
        ok = 1'b1;
        par = 1'b0;
        st = 0;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inf = 1'b0;
            end else begin
                if (!inf) begin
                    if (txd === 1'b0) begin
                        inf = 1'b1;
                        t = 0;
                        st = cyc;
                        b = '0;
                        ok = 1'b1;
                        par = 1'b0;
                    end
                end else begin
                    t++;
                end
                if (inf) begin
                    if (t % BD == BD / 2) begin
                        bi = t / BD;
                        if (bi == 0) ok &= (txd === 1'b0);
                        else if (bi <= 8) b[bi-1] = txd;
                        else if (PAR && bi == 9) par = txd;
                        else ok &= (txd === 1'b1);
                    end
                    if (t == FB * BD - 1) begin
                        mon_byte_q.push_back(b);
                        mon_start_q.push_back(st);
                        mon_ok_q.push_back(ok);
                        mon_par_q.push_back(par);
                        inf = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        mon_byte_q.delete();
        mon_start_q.delete();
        mon_ok_q.delete();
        mon_par_q.delete();
    endtask

    task automatic wait_frames(input int n, input int limit);
        int waited;
        waited = 0;
        while (mon_byte_q.size() < n && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        chk("frames_done", mon_byte_q.size(), n);
    endtask

    // Ideal line level k cycles after a push of b into an idle transmitter.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int bi;
        if (k < 2 || k >= 2 + FB * BD) return 1'b1;
        bi = (k - 2) / BD;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        if (PAR && bi == 9) return ^b;
        return 1'b1;
    endfunction

    initial begin
        int n0;
        int lvl;
        bit dropped;
        logic [7:0] b;
        logic [7:0] exp_q [$];
        logic [7:0] x86 [4];

        x86[0] = 8'h58;
        x86[1] = 8'h38;
        x86[2] = 8'h36;
        x86[3] = 8'h21;

        // Reset and idle
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_byte = '0;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {txd, busy, fifo_level, overflow}, {1'b1, 1'b0, 3'd0, 1'b0});
        end

        // Single byte 0xA5: full waveform and busy fall
        @(posedge clk);
        #1 tx_valid = 1'b1;
        tx_byte = 8'hA5;
        n0 = cyc;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int k = 1; k <= FB * BD + 2; k++) begin
            @(negedge clk);
            chk("a5_cycle", cyc - n0, k);
            chk("a5_txd", txd, exp_line(8'hA5, k));
            chk("a5_busy", busy, (k <= FB * BD + 1));
        end

        // Four back-to-back frames
        repeat (3) @(posedge clk);
        mon_clear();
        #1;
        n0 = cyc;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1;
            tx_byte = x86[i];
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        wait_frames(4, 4 * FB * BD + 50);
        for (int i = 0; i < mon_byte_q.size(); i++) begin
            chk("x86_byte", mon_byte_q[i], x86[i]);
            chk("x86_framing", mon_ok_q[i], 1'b1);
            chk("x86_start", mon_start_q[i], n0 + 2 + i * FB * BD);
        end
        if (mon_start_q.size() == 4)
            chk("x86_span", mon_start_q[3] + FB * BD - mon_start_q[0], 4 * FB * BD);
        repeat (3) @(negedge clk);
        chk("x86_idle_busy", busy, 1'b0);

        // Overflow: six pushes into a depth-4 FIFO, then clear vs. drop priority
        mon_clear();
        exp_q.delete();
        lvl = 0;
        dropped = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            tx_valid = 1'b1;
            tx_byte = b;
            if (lvl < FD) begin
                exp_q.push_back(b);
                lvl++;
            end else begin
                dropped = 1'b1;
            end
            if (i == 1) lvl--;
            @(posedge clk);
            #1;
        end
        tx_byte = 8'($urandom);
        overflow_clr = 1'b1;
        @(negedge clk);
        chk("ovf_set", overflow, dropped);
        chk("ovf_level", fifo_level, lvl);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", overflow, 1'b1);
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow, 1'b0);
        wait_frames(exp_q.size(), exp_q.size() * FB * BD + 60);
        for (int i = 0; i < mon_byte_q.size() && i < exp_q.size(); i++) begin
            chk("ovf_byte", mon_byte_q[i], exp_q[i]);
            chk("ovf_framing", mon_ok_q[i], 1'b1);
        end
        repeat (5) @(negedge clk);
        chk("ovf_no_extra", mon_byte_q.size(), exp_q.size());

        // Random bytes with gaps that never fill the FIFO
        mon_clear();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            b = 8'($urandom);
            exp_q.push_back(b);
            tx_valid = 1'b1;
            tx_byte = b;
            @(posedge clk);
            #1 tx_valid = 1'b0;
            repeat ($urandom_range(40, 80)) @(posedge clk);
        end
        wait_frames(8, 400);
        for (int i = 0; i < mon_byte_q.size() && i < 8; i++) begin
            chk("rand_byte", mon_byte_q[i], exp_q[i]);
            chk("rand_framing", mon_ok_q[i], 1'b1);
        end
        chk("rand_no_ovf", overflow, 1'b0);

`ifdef CARBON_UART_TX_PARITY_EN
        // Parity bits, back-to-back spacing
        mon_clear();
        @(posedge clk);
        #1 tx_valid = 1'b1;
        tx_byte = 8'h07;
        @(posedge clk);
        #1 tx_byte = 8'h03;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_frames(2, 2 * FB * BD + 40);
        if (mon_par_q.size() == 2) begin
            chk("par_07", mon_par_q[0], 1'b1);
            chk("par_03", mon_par_q[1], 1'b0);
            chk("par_spacing", mon_start_q[1] - mon_start_q[0], 44);
        end
`endif

        // Reset during DATA bit 3 of 0xFF with a second byte queued
        repeat (5) @(posedge clk);
        mon_clear();
        #1 tx_valid = 1'b1;
        tx_byte = 8'hFF;
        n0 = cyc;
        @(posedge clk);
        #1 tx_byte = 8'h00;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_pre_cycle", cyc - n0, 19);
        chk("rst_pre_level", fifo_level, 3'd1);
        chk("rst_pre_busy", busy, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_busy", busy, 1'b0);
        repeat (60) @(negedge clk);
        chk("rst_no_frame", mon_byte_q.size(), 0);
        chk("rst_idle_line", {txd, busy, fifo_level, overflow}, {1'b1, 1'b0, 3'd0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
